// File: rtl/egress_cell_gearbox.sv
// Egress cell gearbox: buffers whole 512-bit TM cells, checks SOF/EOF framing and
// serialises each cell into 128-bit MAC beats with packet/byte/error counters.
module egress_cell_gearbox #(
    parameter int CELL_FIFO_DEPTH = 4,
    parameter int BEAT_W          = 128
) (
    input  logic                  clk_dp,
    input  logic                  rst_dp_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic                  in_eof,
    input  logic [6:0]            in_eop_len,
    input  logic [4*BEAT_W-1:0]   in_data,
    output logic                  in_ready,
    output logic                  mac_valid,
    output logic                  mac_sof,
    output logic                  mac_eof,
    output logic [3:0]            mac_empty,
    output logic [BEAT_W-1:0]     mac_data,
    input  logic                  mac_ready,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           byte_cnt,
    output logic [15:0]           err_cnt
);
    localparam int AW = (CELL_FIFO_DEPTH > 1) ? $clog2(CELL_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(CELL_FIFO_DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    // Cell storage: payload plus {sof, eof, len[6:0]}
    logic [4*BEAT_W-1:0] r_mem_data [CELL_FIFO_DEPTH];
    logic [8:0]          r_mem_ctl  [CELL_FIFO_DEPTH];

    logic          r_en;
    logic          r_in_pkt;
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_beat_idx;
    state_t        r_state;
    logic [31:0]   r_pkt_cnt, r_byte_cnt;
    logic [15:0]   r_err_cnt;

    logic          w_accept, w_frame_err, w_len_bad, w_push, w_err_inc;
    logic [6:0]    w_len_store;
    logic [8:0]    w_head_ctl;
    logic [6:0]    w_head_len;
    logic [1:0]    w_beats_m1;
    logic          w_last, w_beat_acc, w_pop;
    logic [6:0]    w_span, w_pad;
    logic [4:0]    w_beat_bytes;
    logic [CW-1:0] w_cnt_nxt;
    state_t        w_state_nxt;
    logic          w_valid;

    assign in_ready    = r_en && (r_cnt < DEPTH_C);
    assign w_accept    = in_valid && in_ready;
    assign w_frame_err = in_sof ? r_in_pkt : !r_in_pkt;
    assign w_len_bad   = in_eof && ((in_eop_len == 7'd0) || (in_eop_len > 7'd64));
    assign w_push      = w_accept && !w_frame_err;
    // Length error only counts for cells that survive the framing check
    assign w_err_inc   = w_accept && (w_frame_err || w_len_bad);
    assign w_len_store = (!in_eof || w_len_bad) ? 7'd64 : in_eop_len;

    assign w_head_ctl   = r_mem_ctl[r_rd_ptr];
    assign w_head_len   = w_head_ctl[6:0];
    assign w_beats_m1   = 2'((w_head_len - 7'd1) >> 4);
    assign w_last       = (r_beat_idx == w_beats_m1);
    assign w_span       = {1'b0, w_beats_m1, 4'b0000} + 7'd16;
    assign w_pad        = w_span - w_head_len;
    assign w_beat_acc   = mac_valid && mac_ready;
    assign w_pop        = w_beat_acc && w_last;
    assign w_beat_bytes = mac_eof ? (5'd16 - {1'b0, mac_empty}) : 5'd16;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk_dp) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_ctl[r_wr_ptr]  <= {in_sof, in_eof, w_len_store};
        end
    end

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            r_en       <= 1'b0;
            r_in_pkt   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_beat_idx <= '0;
        end else begin
            r_en  <= 1'b1;
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (in_eof)      r_in_pkt <= 1'b0;
                else if (in_sof) r_in_pkt <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_beat_idx <= '0;
            end else if (w_beat_acc) begin
                r_beat_idx <= r_beat_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) begin
            r_pkt_cnt  <= '0;
            r_byte_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_beat_acc) r_byte_cnt <= r_byte_cnt + 32'(w_beat_bytes);
            if (w_beat_acc && mac_eof) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_err_inc && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign byte_cnt = r_byte_cnt;
    assign err_cnt  = r_err_cnt;

    always_ff @(posedge clk_dp or negedge rst_dp_n) begin
        if (!rst_dp_n) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // Tracks the post-edge occupancy so SEND coincides with a non-empty FIFO
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cnt_nxt != '0) w_state_nxt = SEND;
            SEND:    if (w_cnt_nxt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_valid   = (r_state == SEND);
        mac_valid = w_valid;
        mac_sof   = 1'b0;
        mac_eof   = 1'b0;
        mac_empty = 4'd0;
        mac_data  = '0;
        if (w_valid) begin
            mac_sof  = w_head_ctl[8] && (r_beat_idx == 2'd0);
            mac_eof  = w_head_ctl[7] && w_last;
            mac_data = r_mem_data[r_rd_ptr][BEAT_W*r_beat_idx +: BEAT_W];
            if (w_head_ctl[7] && w_last) mac_empty = w_pad[3:0];
        end
    end
endmodule

// File: tb/tb_egress_cell_gearbox.sv
// Scoreboard bench for egress_cell_gearbox: expected beats queued as cells are
// accepted, observed beats captured on handshake and compared per scenario.
module tb_egress_cell_gearbox;
    typedef struct packed {
        logic [127:0] data;
        logic         sof;
        logic         eof;
        logic [3:0]   empty;
    } beat_t;

    logic         clk_dp, rst_dp_n;
    logic         in_valid, in_sof, in_eof, in_ready;
    logic [6:0]   in_eop_len;
    logic [511:0] in_data;
    logic         mac_valid, mac_sof, mac_eof, mac_ready;
    logic [3:0]   mac_empty;
    logic [127:0] mac_data;
    logic [31:0]  pkt_cnt, byte_cnt;
    logic [15:0]  err_cnt;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    stamp_q[$];
    int    n_tests, n_fail, cyc;
    int    exp_pkts, exp_bytes, exp_err;

    egress_cell_gearbox #(.CELL_FIFO_DEPTH(4), .BEAT_W(128)) dut (
        .clk_dp(clk_dp), .rst_dp_n(rst_dp_n),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_eop_len(in_eop_len), .in_data(in_data), .in_ready(in_ready),
        .mac_valid(mac_valid), .mac_sof(mac_sof), .mac_eof(mac_eof),
        .mac_empty(mac_empty), .mac_data(mac_data), .mac_ready(mac_ready),
        .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt), .err_cnt(err_cnt)
    );

    initial begin
        clk_dp = 1'b0;
        forever #5 clk_dp = ~clk_dp;
    end

    always @(posedge clk_dp) cyc <= cyc + 1;

    // Inputs only change just after posedge, so a negedge handshake means acceptance
    always @(negedge clk_dp) begin
        if (rst_dp_n && mac_valid && mac_ready) begin
            obs_q.push_back('{data: mac_data, sof: mac_sof, eof: mac_eof, empty: mac_empty});
            stamp_q.push_back(cyc);
        end
    end

    function automatic logic [511:0] rnd_cell();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_expect(input logic sof, input logic eof, input logic [6:0] len,
                               input logic [511:0] d);
        int    l, nb;
        beat_t b;
        l = 64;
        if (eof) begin
            if (len == 0 || len > 64) exp_err++;
            else l = int'(len);
        end
        nb = (l + 15) / 16;
        for (int i = 0; i < nb; i++) begin
            b.data  = d[128*i +: 128];
            b.sof   = sof && (i == 0);
            b.eof   = eof && (i == nb - 1);
            b.empty = b.eof ? 4'(16*nb - l) : 4'd0;
            exp_bytes += b.eof ? (l - 16*i) : 16;
            exp_q.push_back(b);
        end
        if (eof) exp_pkts++;
    endtask

    task automatic drive_cell(input logic sof, input logic eof, input logic [6:0] len,
                              input logic [511:0] d, input logic drop);
        int n;
        in_valid = 1'b1; in_sof = sof; in_eof = eof; in_eop_len = len; in_data = d;
        n = 0;
        @(negedge clk_dp);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk_dp);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end else if (drop) exp_err++;
        else push_expect(sof, eof, len, d);
        @(posedge clk_dp); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 1000) begin
            @(posedge clk_dp); #1;
            n++;
        end
        if (obs_q.size() < exp_q.size()) begin
            n_tests++; n_fail++;
            $display("FAIL %s drain: got %0d beats required %0d", tag, obs_q.size(), exp_q.size());
        end
        @(posedge clk_dp); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_dp);
        n_tests++;
        if ({in_ready, mac_valid, mac_sof, mac_eof, mac_empty} !== 8'd0 || mac_data !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b sof=%b eof=%b empty=%0d required all 0",
                     in_ready, mac_valid, mac_sof, mac_eof, mac_empty);
        end
        n_tests++;
        if ({pkt_cnt, byte_cnt, err_cnt} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_counters: pkt=%0d byte=%0d err=%0d required 0", pkt_cnt, byte_cnt, err_cnt);
        end
        rst_dp_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        @(posedge clk_dp); #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_cell();
        logic [511:0] d;
        beat_t e, o;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        mac_ready = 1'b1;
        drive_cell(1'b1, 1'b1, 7'd40, d, 1'b0);
        n_tests++;
        if (mac_valid !== 1'b1 || mac_sof !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: vld=%b sof=%b required 1 1", mac_valid, mac_sof);
        end
        wait_drain("single");
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL single_beat: got %h required %h", o, e);
            end
        end
        n_tests++;
        if (byte_cnt !== 32'd40 || pkt_cnt !== 32'd1) begin
            n_fail++; $display("FAIL single_counters: byte=%0d pkt=%0d required 40 1", byte_cnt, pkt_cnt);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_back_to_back();
        beat_t e, o;
        int    first, idx;
        mac_ready = 1'b1;
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b0);
        drive_cell(1'b0, 1'b0, 7'd64, rnd_cell(), 1'b0);
        drive_cell(1'b0, 1'b1, 7'd64, rnd_cell(), 1'b0);
        wait_drain("b2b");
        first = (stamp_q.size() != 0) ? stamp_q[0] : 0;
        idx = 0;
        n_tests++;
        if (obs_q.size() !== 12) begin
            n_fail++; $display("FAIL b2b_count: got %0d beats required 12", obs_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e || stamp_q[idx] !== first + idx) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h cyc %0d required %h cyc %0d",
                                   idx, o, stamp_q[idx], e, first + idx);
            end
            idx++;
        end
        n_tests++;
        if (byte_cnt !== 32'(exp_bytes) || pkt_cnt !== 32'(exp_pkts)) begin
            n_fail++; $display("FAIL b2b_counters: byte=%0d pkt=%0d required %0d %0d",
                               byte_cnt, pkt_cnt, exp_bytes, exp_pkts);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_full_fifo();
        beat_t e, o;
        logic [511:0] d5;
        mac_ready = 1'b0;
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b0);
        for (int i = 0; i < 3; i++) drive_cell(1'b0, 1'b0, 7'd64, rnd_cell(), 1'b0);
        d5 = rnd_cell();
        in_valid = 1'b1; in_sof = 1'b0; in_eof = 1'b0; in_eop_len = 7'd64; in_data = d5;
        repeat (2) begin
            @(negedge clk_dp); n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL full_stalled: in_ready=%b required 0", in_ready);
            end
            @(posedge clk_dp); #1;
        end
        mac_ready = 1'b1;
        // Head cell needs four beats; the slot frees only after the fourth is taken
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_dp); n_tests++;
            if (in_ready !== (i == 4)) begin
                n_fail++; $display("FAIL full_ready_c%0d: in_ready=%b required %b", i, in_ready, i == 4);
            end
            if (i < 4) begin @(posedge clk_dp); #1; end
        end
        push_expect(1'b0, 1'b0, 7'd64, d5);
        @(posedge clk_dp); #1;
        in_valid = 1'b0;
        drive_cell(1'b0, 1'b1, 7'd50, rnd_cell(), 1'b0);
        wait_drain("full");
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL full_beat: got %h required %h", o, e);
            end
        end
        n_tests++;
        if (byte_cnt !== 32'(exp_bytes) || pkt_cnt !== 32'(exp_pkts)) begin
            n_fail++; $display("FAIL full_counters: byte=%0d pkt=%0d required %0d %0d",
                               byte_cnt, pkt_cnt, exp_bytes, exp_pkts);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_backpressure();
        beat_t e, o, held, cur;
        logic  stalled;
        mac_ready = 1'b0;
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b0);
        drive_cell(1'b0, 1'b1, 7'd20, rnd_cell(), 1'b0);
        stalled = 1'b0;
        held = '0;
        for (int c = 0; c < 60 && obs_q.size() < 6; c++) begin
            mac_ready = (c % 2) == 1;
            @(negedge clk_dp);
            cur = '{data: mac_data, sof: mac_sof, eof: mac_eof, empty: mac_empty};
            if (stalled) begin
                n_tests++;
                if ({mac_valid, cur} !== {1'b1, held}) begin
                    n_fail++; $display("FAIL bp_stable: vld=%b got %h required %h", mac_valid, cur, held);
                end
            end
            stalled = mac_valid && !mac_ready;
            held = cur;
            @(posedge clk_dp); #1;
        end
        mac_ready = 1'b1;
        wait_drain("bp");
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL bp_beat: got %h required %h", o, e);
            end
        end
        n_tests++;
        if (byte_cnt !== 32'(exp_bytes)) begin
            n_fail++; $display("FAIL bp_bytes: got %0d required %0d", byte_cnt, exp_bytes);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_framing_error();
        beat_t e, o;
        mac_ready = 1'b1;
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b0);
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b1);
        drive_cell(1'b0, 1'b1, 7'd30, rnd_cell(), 1'b0);
        wait_drain("frame");
        n_tests++;
        if (obs_q.size() !== 6) begin
            n_fail++; $display("FAIL frame_count: got %0d beats required 6", obs_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL frame_beat: got %h required %h", o, e);
            end
        end
        n_tests++;
        if (err_cnt !== 16'(exp_err) || pkt_cnt !== 32'(exp_pkts)) begin
            n_fail++; $display("FAIL frame_counters: err=%0d pkt=%0d required %0d %0d",
                               err_cnt, pkt_cnt, exp_err, exp_pkts);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_bad_length();
        beat_t e, o;
        mac_ready = 1'b1;
        drive_cell(1'b1, 1'b1, 7'd0, rnd_cell(), 1'b0);
        drive_cell(1'b1, 1'b1, 7'd127, rnd_cell(), 1'b0);
        wait_drain("badlen");
        n_tests++;
        if (obs_q.size() !== 8) begin
            n_fail++; $display("FAIL badlen_count: got %0d beats required 8", obs_q.size());
        end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin
                n_fail++; $display("FAIL badlen_beat: got %h required %h", o, e);
            end
        end
        n_tests++;
        if (err_cnt !== 16'(exp_err) || byte_cnt !== 32'(exp_bytes)) begin
            n_fail++; $display("FAIL badlen_counters: err=%0d byte=%0d required %0d %0d",
                               err_cnt, byte_cnt, exp_err, exp_bytes);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
    endtask

    task automatic test_reset_mid();
        mac_ready = 1'b0;
        drive_cell(1'b1, 1'b0, 7'd64, rnd_cell(), 1'b0);
        @(negedge clk_dp);
        n_tests++;
        if (mac_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_valid: got %b required 1", mac_valid);
        end
        #2 rst_dp_n = 1'b0;
        #1;
        n_tests++;
        if (mac_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_valid: vld=%b rdy=%b required 0 0", mac_valid, in_ready);
        end
        n_tests++;
        if ({pkt_cnt, byte_cnt, err_cnt} !== 80'd0) begin
            n_fail++; $display("FAIL mid_reset_counters: pkt=%0d byte=%0d err=%0d required 0",
                               pkt_cnt, byte_cnt, err_cnt);
        end
        exp_q.delete(); obs_q.delete(); stamp_q.delete();
        exp_pkts = 0; exp_bytes = 0; exp_err = 0;
        @(negedge clk_dp);
        rst_dp_n = 1'b1;
        repeat (2) @(posedge clk_dp);
        #1;
        n_tests++;
        if (mac_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_after_release: vld=%b rdy=%b required 0 1", mac_valid, in_ready);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        exp_pkts = 0; exp_bytes = 0; exp_err = 0;
        rst_dp_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_eop_len = 7'd0; in_data = '0;
        mac_ready = 1'b0;
        test_reset();
        test_single_cell();
        test_back_to_back();
        test_full_fifo();
        test_backpressure();
        test_framing_error();
        test_bad_length();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
